// File: rtl/minesweeper_pkg.sv
// Shared types and constants for the minesweeper display path.
// Holds the grid scheduler state encoding and the drawBox job-type encoding.
package minesweeper_pkg;

    localparam logic [3:0] CELL_BOMB = 4'd9;
    localparam int X_W     = 8;
    localparam int Y_W     = 7;
    localparam int COUNT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE_B,
        S_WAIT_B,
        S_ISSUE_R,
        S_WAIT_R,
        S_NEXT,
        S_DONE
    } sched_state_e;

    // Job type as seen by drawBox: cursor selects the border, reveal the glyph.
    typedef struct packed {
        logic cursor;
        logic reveal;
    } job_t;

    localparam job_t JOB_NONE   = '{cursor: 1'b0, reveal: 1'b0};
    localparam job_t JOB_BORDER = '{cursor: 1'b1, reveal: 1'b0};
    localparam job_t JOB_GLYPH  = '{cursor: 1'b0, reveal: 1'b1};

endpackage

// File: rtl/grid_draw_scheduler_neighbour_counter.sv
// Combinational count of bombs in the up-to-eight neighbours of one cell.
// Neighbours off the board are excluded; rows and columns never wrap.
module neighbour_counter
    import minesweeper_pkg::*;
#(
    parameter int GRID_SIZE = 3,
    parameter int RW        = 2
) (
    input  logic [GRID_SIZE*GRID_SIZE-1:0] bomb_grid,
    input  logic [RW-1:0]                  row,
    input  logic [RW-1:0]                  col,
    output logic [COUNT_W-1:0]             count
);

    // Row and column are tested separately so a cell at the end of one row never sees the next.
    always_comb begin
        count = '0;
        for (int i = 0; i < GRID_SIZE * GRID_SIZE; i++) begin
            if (bomb_grid[i] &&
                ((i / GRID_SIZE) + 1 >= int'(row)) && ((i / GRID_SIZE) <= int'(row) + 1) &&
                ((i % GRID_SIZE) + 1 >= int'(col)) && ((i % GRID_SIZE) <= int'(col) + 1) &&
                !(((i / GRID_SIZE) == int'(row)) && ((i % GRID_SIZE) == int'(col)))) begin
                count = count + COUNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/grid_draw_scheduler.sv
// Walks every board cell on a redraw request and hands border/glyph jobs to drawBox,
// waiting for each job to complete before moving on.
module grid_draw_scheduler
    import minesweeper_pkg::*;
#(
    parameter int GRID_SIZE = 3,
    parameter int BOX_PITCH = 10,
    parameter int ORIGIN_X  = 0,
    parameter int ORIGIN_Y  = 0
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           reveal_all,
    input  logic [GRID_SIZE*GRID_SIZE-1:0] bombGrid,
    input  logic [GRID_SIZE*GRID_SIZE-1:0] revealGrid,
    input  logic [GRID_SIZE*GRID_SIZE-1:0] cursorGrid,
    input  logic                           box_done,
    output logic [X_W-1:0]                 box_x,
    output logic [Y_W-1:0]                 box_y,
    output logic                           d_enable,
    output logic                           d_cursor,
    output logic                           d_reveal,
    output logic                           cursor_bit,
    output logic [3:0]                     cell_state,
    output logic                           busy,
    output logic                           frame_done
);

    localparam int N  = GRID_SIZE * GRID_SIZE;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = (GRID_SIZE > 1) ? $clog2(GRID_SIZE) : 1;

    sched_state_e   state_q, state_d;
    logic [KW-1:0]  k_q, k_d;
    logic [RW-1:0]  row_q, row_d, col_q, col_d;
    logic [X_W-1:0] x_acc_q, x_acc_d, box_x_q, box_x_d;
    logic [Y_W-1:0] y_acc_q, y_acc_d, box_y_q, box_y_d;
    logic [N-1:0]   bomb_snap_q, bomb_snap_d, reveal_snap_q, reveal_snap_d;
    logic [N-1:0]   cursor_snap_q, cursor_snap_d;
    logic           reveal_all_snap_q, reveal_all_snap_d;
    logic [3:0]     cell_state_q, cell_state_d;
    logic           cursor_bit_q, cursor_bit_d;
    logic           d_enable_q, d_enable_d, d_cursor_q, d_cursor_d, d_reveal_q, d_reveal_d;
    logic           busy_q, busy_d, frame_done_q, frame_done_d;
    logic [COUNT_W-1:0] nb_count;
    job_t           job;

    neighbour_counter #(
        .GRID_SIZE(GRID_SIZE),
        .RW       (RW)
    ) u_neighbour_counter (
        .bomb_grid(bomb_snap_q),
        .row      (row_q),
        .col      (col_q),
        .count    (nb_count)
    );

    always_comb begin
        state_d           = state_q;
        k_d               = k_q;
        row_d             = row_q;
        col_d             = col_q;
        x_acc_d           = x_acc_q;
        y_acc_d           = y_acc_q;
        bomb_snap_d       = bomb_snap_q;
        reveal_snap_d     = reveal_snap_q;
        cursor_snap_d     = cursor_snap_q;
        reveal_all_snap_d = reveal_all_snap_q;
        box_x_d           = box_x_q;
        box_y_d           = box_y_q;
        cell_state_d      = cell_state_q;
        cursor_bit_d      = cursor_bit_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bomb_snap_d       = bombGrid;
                    reveal_snap_d     = revealGrid;
                    cursor_snap_d     = cursorGrid;
                    reveal_all_snap_d = reveal_all;
                    k_d               = '0;
                    row_d             = '0;
                    col_d             = '0;
                    x_acc_d           = X_W'(ORIGIN_X);
                    y_acc_d           = Y_W'(ORIGIN_Y);
                    state_d           = S_LOAD;
                end
            end
            S_LOAD: begin
                box_x_d      = x_acc_q;
                box_y_d      = y_acc_q;
                cell_state_d = bomb_snap_q[k_q] ? CELL_BOMB : nb_count;
                cursor_bit_d = cursor_snap_q[k_q];
                state_d      = S_ISSUE_B;
            end
            S_ISSUE_B: state_d = S_WAIT_B;
            S_WAIT_B: begin
                if (box_done) begin
                    state_d = (reveal_snap_q[k_q] | reveal_all_snap_q) ? S_ISSUE_R : S_NEXT;
                end
            end
            S_ISSUE_R: state_d = S_WAIT_R;
            S_WAIT_R: begin
                if (box_done) begin
                    state_d = S_NEXT;
                end
            end
            // Origins advance by accumulation; x snaps back to the left edge on a row wrap.
            S_NEXT: begin
                if (k_q == KW'(N - 1)) begin
                    state_d = S_DONE;
                end else begin
                    k_d     = k_q + KW'(1);
                    state_d = S_LOAD;
                    if (col_q == RW'(GRID_SIZE - 1)) begin
                        col_d   = '0;
                        row_d   = row_q + RW'(1);
                        x_acc_d = X_W'(ORIGIN_X);
                        y_acc_d = y_acc_q + Y_W'(BOX_PITCH);
                    end else begin
                        col_d   = col_q + RW'(1);
                        x_acc_d = x_acc_q + X_W'(BOX_PITCH);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        job = JOB_NONE;
        if (state_d == S_ISSUE_B) begin
            job = JOB_BORDER;
        end else if (state_d == S_ISSUE_R) begin
            job = JOB_GLYPH;
        end
        d_enable_d   = (state_d == S_ISSUE_B) || (state_d == S_ISSUE_R);
        d_cursor_d   = job.cursor;
        d_reveal_d   = job.reveal;
        busy_d       = (state_d != S_IDLE) && (state_d != S_DONE);
        frame_done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q           <= S_IDLE;
            k_q               <= '0;
            row_q             <= '0;
            col_q             <= '0;
            x_acc_q           <= '0;
            y_acc_q           <= '0;
            bomb_snap_q       <= '0;
            reveal_snap_q     <= '0;
            cursor_snap_q     <= '0;
            reveal_all_snap_q <= 1'b0;
            box_x_q           <= '0;
            box_y_q           <= '0;
            cell_state_q      <= '0;
            cursor_bit_q      <= 1'b0;
            d_enable_q        <= 1'b0;
            d_cursor_q        <= 1'b0;
            d_reveal_q        <= 1'b0;
            busy_q            <= 1'b0;
            frame_done_q      <= 1'b0;
        end else begin
            state_q           <= state_d;
            k_q               <= k_d;
            row_q             <= row_d;
            col_q             <= col_d;
            x_acc_q           <= x_acc_d;
            y_acc_q           <= y_acc_d;
            bomb_snap_q       <= bomb_snap_d;
            reveal_snap_q     <= reveal_snap_d;
            cursor_snap_q     <= cursor_snap_d;
            reveal_all_snap_q <= reveal_all_snap_d;
            box_x_q           <= box_x_d;
            box_y_q           <= box_y_d;
            cell_state_q      <= cell_state_d;
            cursor_bit_q      <= cursor_bit_d;
            d_enable_q        <= d_enable_d;
            d_cursor_q        <= d_cursor_d;
            d_reveal_q        <= d_reveal_d;
            busy_q            <= busy_d;
            frame_done_q      <= frame_done_d;
        end
    end

    assign box_x      = box_x_q;
    assign box_y      = box_y_q;
    assign cell_state = cell_state_q;
    assign cursor_bit = cursor_bit_q;
    assign d_enable   = d_enable_q;
    assign d_cursor   = d_cursor_q;
    assign d_reveal   = d_reveal_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_grid_draw_scheduler.sv
// Scoreboard bench for grid_draw_scheduler: a reference model queues the expected job stream
// per frame, a monitor pops it as jobs appear, and a responder plays drawBox.
module tb_grid_draw_scheduler;

    localparam int G     = 3;
    localparam int N     = G * G;
    localparam int PITCH = 10;
    localparam int OX    = 0;
    localparam int OY    = 0;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         reveal_all = 1'b0;
    logic         box_done = 1'b0;
    logic [N-1:0] bombGrid = '0;
    logic [N-1:0] revealGrid = '0;
    logic [N-1:0] cursorGrid = '0;
    logic [7:0]   box_x;
    logic [6:0]   box_y;
    logic         d_enable, d_cursor, d_reveal, cursor_bit, busy, frame_done;
    logic [3:0]   cell_state;

    // kind: 0 = border job, 1 = glyph job, 2 = end of frame
    typedef struct {
        int kind;
        int x;
        int y;
        int cs;
        int cb;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   failures = 0;
    int   borderCount = 0;
    int   glyphCount = 0;
    int   doneDelay = 3;

    grid_draw_scheduler #(
        .GRID_SIZE(G),
        .BOX_PITCH(PITCH),
        .ORIGIN_X (OX),
        .ORIGIN_Y (OY)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .reveal_all(reveal_all),
        .bombGrid  (bombGrid),
        .revealGrid(revealGrid),
        .cursorGrid(cursorGrid),
        .box_done  (box_done),
        .box_x     (box_x),
        .box_y     (box_y),
        .d_enable  (d_enable),
        .d_cursor  (d_cursor),
        .d_reveal  (d_reveal),
        .cursor_bit(cursor_bit),
        .cell_state(cell_state),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int bitAt(input logic [N-1:0] v, input int i);
        logic [N-1:0] t;
        t = v >> i;
        return int'(t[0]);
    endfunction

    // Minesweeper rule: bomb -> 9, otherwise count bombs among on-board neighbours.
    function automatic int refCellState(input int k, input logic [N-1:0] bomb);
        int r, c, n;
        r = k / G;
        c = k % G;
        n = 0;
        if (bitAt(bomb, k) == 1) return 9;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < G && c + dc >= 0 && c + dc < G) begin
                    n += bitAt(bomb, (r + dr) * G + (c + dc));
                end
            end
        end
        return n;
    endfunction

    task automatic applyStimulus(input logic [N-1:0] bomb, input logic [N-1:0] rev,
                                 input logic [N-1:0] cur, input logic revAll, input bit spurious);
        exp_t e;
        @(negedge clock);
        bombGrid   = bomb;
        revealGrid = rev;
        cursorGrid = cur;
        reveal_all = revAll;
        for (int k = 0; k < N; k++) begin
            e.kind = 0;
            e.x    = (OX + (k % G) * PITCH) % 256;
            e.y    = (OY + (k / G) * PITCH) % 128;
            e.cs   = refCellState(k, bomb);
            e.cb   = bitAt(cur, k);
            expQ.push_back(e);
            if (bitAt(rev, k) == 1 || revAll) begin
                e.kind = 1;
                expQ.push_back(e);
            end
        end
        e.kind = 2;
        expQ.push_back(e);
        borderCount = 0;
        glyphCount  = 0;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        if (spurious) begin
            box_done = 1'b1;
            @(posedge clock);
            #1 box_done = 1'b0;
        end
    endtask

    task automatic waitFrame(input bit dropStart);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 4000 && !seen; i++) begin
            @(negedge clock);
            if (frame_done) seen = 1'b1;
        end
        checkOutput("frame_done_seen", int'(seen), 1);
        if (seen && dropStart) begin
            start = 1'b1;
            @(posedge clock);
            #1 start = 1'b0;
        end
        repeat (3) @(negedge clock);
        checkOutput("idle_busy", int'(busy), 0);
        checkOutput("queue_empty", expQ.size(), 0);
        expQ.delete();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_box_x"}, int'(box_x), 0);
        checkOutput({tag, "_box_y"}, int'(box_y), 0);
        checkOutput({tag, "_cell_state"}, int'(cell_state), 0);
        checkOutput({tag, "_cursor_bit"}, int'(cursor_bit), 0);
        checkOutput({tag, "_d_enable"}, int'(d_enable), 0);
        checkOutput({tag, "_d_cursor"}, int'(d_cursor), 0);
        checkOutput({tag, "_d_reveal"}, int'(d_reveal), 0);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_frame_done"}, int'(frame_done), 0);
    endtask

    // drawBox stand-in: completes each job dly cycles after its strobe.
    initial begin
        forever begin
            @(negedge clock);
            while (d_enable && !reset) begin
                int dly;
                dly = (doneDelay == 0) ? int'($urandom_range(1, 4)) : doneDelay;
                repeat (dly) @(negedge clock);
                box_done = 1'b1;
                @(negedge clock);
                box_done = 1'b0;
            end
        end
    end

    // Monitor: every strobe or frame_done must match the head of the expected queue.
    always @(negedge clock) begin
        if (!reset && (d_enable || frame_done)) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                if (e.kind == 2) begin
                    checkOutput("frame_done", int'(frame_done), 1);
                    checkOutput("end_d_enable", int'(d_enable), 0);
                end else begin
                    checkOutput("d_enable", int'(d_enable), 1);
                    checkOutput("d_cursor", int'(d_cursor), (e.kind == 0) ? 1 : 0);
                    checkOutput("d_reveal", int'(d_reveal), (e.kind == 1) ? 1 : 0);
                    checkOutput("box_x", int'(box_x), e.x);
                    checkOutput("box_y", int'(box_y), e.y);
                    checkOutput("cell_state", int'(cell_state), e.cs);
                    checkOutput("cursor_bit", int'(cursor_bit), e.cb);
                    if (d_cursor) borderCount++;
                    if (d_reveal) glyphCount++;
                end
            end
        end
    end

    initial begin
        bit found;
        repeat (3) @(negedge clock);
        checkAllZero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Plain frame, fixed drawBox latency; a start in the DONE cycle must be dropped.
        doneDelay = 3;
        applyStimulus('0, '0, '0, 1'b0, 1'b0);
        waitFrame(1'b1);
        checkOutput("t2_border_count", borderCount, 9);
        checkOutput("t2_glyph_count", glyphCount, 0);

        applyStimulus(9'b000010000, '1, '0, 1'b0, 1'b0);
        waitFrame(1'b0);

        applyStimulus(9'b000000110, '0, '0, 1'b1, 1'b0);
        waitFrame(1'b0);

        // Cursor, spurious box_done in LOAD, and a start while busy.
        doneDelay = 0;
        applyStimulus(N'($urandom), '0, 9'b000100000, 1'b0, 1'b1);
        repeat (10) @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        waitFrame(1'b0);

        // reveal_all with grid inputs scrambled mid-frame.
        applyStimulus(N'($urandom), '0, 9'b000000001, 1'b1, 1'b0);
        repeat (6) @(negedge clock);
        bombGrid   = N'($urandom);
        revealGrid = N'($urandom);
        cursorGrid = N'($urandom);
        waitFrame(1'b0);
        checkOutput("t6_border_count", borderCount, 9);
        checkOutput("t6_glyph_count", glyphCount, 9);

        // Reset while waiting on a glyph job, then a fresh frame from cell 0.
        doneDelay = 8;
        applyStimulus(N'($urandom), '1, '0, 1'b0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clock);
            if (d_enable && d_reveal) found = 1'b1;
        end
        checkOutput("t1_reached_glyph", int'(found), 1);
        @(negedge clock);
        reset = 1'b1;
        expQ.delete();
        repeat (3) @(negedge clock);
        checkAllZero("midreset");
        reset = 1'b0;
        repeat (12) @(negedge clock);
        checkAllZero("postreset");
        doneDelay = 0;
        applyStimulus(N'($urandom), N'($urandom), 9'b000000001, 1'b0, 1'b0);
        waitFrame(1'b0);

        for (int f = 0; f < 6; f++) begin
            applyStimulus(N'($urandom), N'($urandom), N'(1) << $urandom_range(0, N - 1),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            waitFrame(1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
